// File: rtl/arbiter_main_if.sv
// Request/grant bundle between the issue queue and a fixed-priority arbiter.
// The master drives ready; the slave (arbiter) returns the grant and debug index.
interface arbiter_main_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] ready;
   logic [WIDTH-1:0] grant;
   logic [31:0]      granted;
   logic             valid;
   logic [31:0]      last_granted;

   modport master (
      output ready,
      input  grant,
      input  granted,
      input  valid,
      input  last_granted
   );

   modport slave (
      input  ready,
      output grant,
      output granted,
      output valid,
      output last_granted
   );
endinterface

// File: rtl/arbiter_main.sv
// Fixed-priority one-hot arbiter / priority encoder with a registered last-grant index.
// Define ARBITER_MAIN_REG_OUT_EN to register grant/granted/valid (1-cycle latency).
module arbiter_main #(
   parameter int WIDTH     = 16,
   parameter int DIRECTION = 0
) (
   input logic           CLK,
   input logic           RESET,
   arbiter_main_if.slave bus
);

   logic [WIDTH-1:0] grant_d;
   logic [31:0]      granted_d;
   logic             valid_d;
   logic [31:0]      scan_idx_d;
   logic [WIDTH-1:0] ready_shift_d;
   logic [31:0]      last_granted_q;

   // Scan toward the preferred end so the winning request is the last one written.
   always_comb begin
      grant_d       = {WIDTH{1'b0}};
      granted_d     = 32'(WIDTH);
      valid_d       = 1'b0;
      scan_idx_d    = 32'd0;
      ready_shift_d = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         if (DIRECTION == 0) begin
            scan_idx_d = 32'(WIDTH - 1 - i);
         end else begin
            scan_idx_d = 32'(i);
         end
         ready_shift_d = bus.ready >> scan_idx_d;
         if (ready_shift_d[0]) begin
            grant_d   = WIDTH'(1'b1) << scan_idx_d;
            granted_d = scan_idx_d;
            valid_d   = 1'b1;
         end else begin
            valid_d   = valid_d;
         end
      end
   end

`ifdef ARBITER_MAIN_REG_OUT_EN
   logic [WIDTH-1:0] grant_q;
   logic [31:0]      granted_q;
   logic             valid_q;

   // Output register stage: selection reflects ready from the previous edge.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         grant_q   <= {WIDTH{1'b0}};
         granted_q <= 32'(WIDTH);
         valid_q   <= 1'b0;
      end else begin
         grant_q   <= grant_d;
         granted_q <= granted_d;
         valid_q   <= valid_d;
      end
   end

   // Debug copy follows the registered selection, one cycle behind it.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         last_granted_q <= 32'(WIDTH);
      end else if (valid_q) begin
         last_granted_q <= granted_q;
      end else begin
         last_granted_q <= last_granted_q;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.granted = granted_q;
   assign bus.valid   = valid_q;
`else
   // Debug copy of the most recent valid selection; holds while nothing is requested.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         last_granted_q <= 32'(WIDTH);
      end else if (valid_d) begin
         last_granted_q <= granted_d;
      end else begin
         last_granted_q <= last_granted_q;
      end
   end

   assign bus.grant   = grant_d;
   assign bus.granted = granted_d;
   assign bus.valid   = valid_d;
`endif

   assign bus.last_granted = last_granted_q;

endmodule

// File: tb/tb_arbiter_main.sv
// Directed, table-driven bench for arbiter_main in both scan directions.
// Works for the default combinational build and the ARBITER_MAIN_REG_OUT_EN build.
module tb_arbiter_main;

   logic CLK;
   logic RESET;

   arbiter_main_if #(.WIDTH(16)) if0 ();
   arbiter_main_if #(.WIDTH(16)) if1 ();

   arbiter_main #(.WIDTH(16), .DIRECTION(0)) dut0 (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (if0)
   );

   arbiter_main #(.WIDTH(16), .DIRECTION(1)) dut1 (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (if1)
   );

   typedef struct {
      logic [15:0] ready;
      logic [15:0] grant0;
      logic [31:0] idx0;
      logic [15:0] grant1;
      logic [31:0] idx1;
      logic        valid;
   } vec_t;

   int          errors;
   int          checks;
   logic [31:0] exp_last0;
   logic [31:0] exp_last1;
   vec_t        vecs [10];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge CLK);
      if0.ready = v.ready;
      if1.ready = v.ready;
`ifdef ARBITER_MAIN_REG_OUT_EN
      @(posedge CLK);
      #1;
`else
      #1;
`endif
      chk($sformatf("grant0 r=%h", v.ready),   {16'h0000, if0.grant}, {16'h0000, v.grant0});
      chk($sformatf("granted0 r=%h", v.ready), if0.granted, v.idx0);
      chk($sformatf("valid0 r=%h", v.ready),   {31'd0, if0.valid}, {31'd0, v.valid});
      chk($sformatf("grant1 r=%h", v.ready),   {16'h0000, if1.grant}, {16'h0000, v.grant1});
      chk($sformatf("granted1 r=%h", v.ready), if1.granted, v.idx1);
      chk($sformatf("valid1 r=%h", v.ready),   {31'd0, if1.valid}, {31'd0, v.valid});
      if (v.valid) begin
         exp_last0 = v.idx0;
         exp_last1 = v.idx1;
      end
      @(posedge CLK);
      #1;
      chk($sformatf("last0 r=%h", v.ready), if0.last_granted, exp_last0);
      chk($sformatf("last1 r=%h", v.ready), if1.last_granted, exp_last1);
   endtask

   initial begin
      vec_t sv;
      errors = 0;
      checks = 0;

      vecs[0] = '{16'h0000, 16'h0000, 32'd16, 16'h0000, 32'd16, 1'b0};
      vecs[1] = '{16'h0028, 16'h0008, 32'd3,  16'h0020, 32'd5,  1'b1};
      vecs[2] = '{16'hFFFF, 16'h0001, 32'd0,  16'h8000, 32'd15, 1'b1};
      vecs[3] = '{16'h8000, 16'h8000, 32'd15, 16'h8000, 32'd15, 1'b1};
      vecs[4] = '{16'h0000, 16'h0000, 32'd16, 16'h0000, 32'd16, 1'b0};
      vecs[5] = '{16'h0001, 16'h0001, 32'd0,  16'h0001, 32'd0,  1'b1};
      vecs[6] = '{16'h8001, 16'h0001, 32'd0,  16'h8000, 32'd15, 1'b1};
      vecs[7] = '{16'h0F00, 16'h0100, 32'd8,  16'h0800, 32'd11, 1'b1};
      vecs[8] = '{16'h1234, 16'h0004, 32'd2,  16'h1000, 32'd12, 1'b1};
      vecs[9] = '{16'h0000, 16'h0000, 32'd16, 16'h0000, 32'd16, 1'b0};

      // Reset with no requests
      RESET     = 1'b0;
      if0.ready = 16'h0000;
      if1.ready = 16'h0000;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset grant0",   {16'h0000, if0.grant}, 32'd0);
      chk("reset granted0", if0.granted, 32'd16);
      chk("reset valid0",   {31'd0, if0.valid}, 32'd0);
      chk("reset last0",    if0.last_granted, 32'd16);
      chk("reset granted1", if1.granted, 32'd16);
      chk("reset last1",    if1.last_granted, 32'd16);
      exp_last0 = 32'd16;
      exp_last1 = 32'd16;
      @(negedge CLK);
      RESET = 1'b1;

      // Directed table
      for (int i = 0; i < 10; i++) begin
         apply(vecs[i]);
      end

      // One-hot sweep: both directions must pick the single request
      for (int i = 0; i < 16; i++) begin
         sv.ready  = 16'h0001 << i;
         sv.grant0 = 16'h0001 << i;
         sv.grant1 = 16'h0001 << i;
         sv.idx0   = 32'(i);
         sv.idx1   = 32'(i);
         sv.valid  = 1'b1;
         apply(sv);
      end

      // Reset asserted mid-stream
      apply(vecs[1]);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      chk("midrst pre-edge granted0", if0.granted, 32'd3);
      @(posedge CLK);
      #1;
      chk("midrst last0", if0.last_granted, 32'd16);
      chk("midrst last1", if1.last_granted, 32'd16);
`ifdef ARBITER_MAIN_REG_OUT_EN
      chk("midrst granted0", if0.granted, 32'd16);
      chk("midrst valid0",   {31'd0, if0.valid}, 32'd0);
      chk("midrst granted1", if1.granted, 32'd16);
`else
      chk("midrst granted0", if0.granted, 32'd3);
      chk("midrst valid0",   {31'd0, if0.valid}, 32'd1);
      chk("midrst granted1", if1.granted, 32'd5);
`endif
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      chk("postrst granted0", if0.granted, 32'd3);

      // Latency of a new request
      @(negedge CLK);
      if0.ready = 16'h0010;
      if1.ready = 16'h0010;
      #1;
`ifdef ARBITER_MAIN_REG_OUT_EN
      chk("latency before edge granted0", if0.granted, 32'd3);
      @(posedge CLK);
      #1;
      chk("latency after edge granted0", if0.granted, 32'd4);
      chk("latency after edge grant1", {16'h0000, if1.grant}, 32'h0010);
`else
      chk("zero latency granted0", if0.granted, 32'd4);
      chk("zero latency grant1", {16'h0000, if1.grant}, 32'h0010);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
